// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock duty-cycle monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMeasHigh,
        StMeasLow
    } mon_state_e;

    // Quotient bits produced by the divider; duty <= 100 fits in 7 bits.
    localparam int unsigned DIV_ITER  = 7;
    localparam int unsigned PCT_SCALE = 100;

    // True when |duty - exp_pct| exceeds tol.
    function automatic logic duty_out_of_tol(input logic [6:0] duty,
                                             input int unsigned exp_pct,
                                             input int unsigned tol);
        int unsigned d;
        int unsigned diff;
        d    = {25'd0, duty};
        diff = (d > exp_pct) ? (d - exp_pct) : (exp_pct - d);
        return diff > tol;
    endfunction

endpackage

// File: rtl/clk_mon_div.sv
// Restoring divider for the duty-cycle monitor: one quotient bit per cycle,
// DIV_ITER cycles per division. done is a combinational pulse in the last
// iteration cycle with quot valid alongside it.
module clk_mon_div
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W+6:0]    num,
    input  logic [CNT_W:0]      den,
    output logic                busy,
    output logic                done,
    output logic [DIV_ITER-1:0] quot
);

    logic [CNT_W+6:0]    rem_q;
    logic [CNT_W+6:0]    dsh_q;
    logic [DIV_ITER-1:0] q_q;
    logic [2:0]          iter_q;
    logic                busy_q;
    logic                ge;

    // Divisor starts shifted to the top quotient bit and walks right.
    assign ge   = (rem_q >= dsh_q);
    assign quot = {q_q[DIV_ITER-2:0], ge};
    assign done = busy_q && (iter_q == 3'(DIV_ITER - 1));
    assign busy = busy_q;

    // Load on start, then one restoring step per cycle until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            q_q    <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            rem_q  <= num;
            dsh_q  <= {den, {(DIV_ITER - 1){1'b0}}};
            q_q    <= '0;
            iter_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (ge) begin
                rem_q <= rem_q - dsh_q;
            end
            dsh_q  <= dsh_q >> 1;
            q_q    <= quot;
            iter_q <= iter_q + 3'd1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_duty_monitor.sv
// Clock duty-cycle monitor: synchronizes a clock under test, measures high/low
// time in sampling-clock cycles, reports period and integer duty percent, and
// flags out-of-tolerance duty and stuck clocks.
// Optional build macro CLK_MON_MINMAX_EN adds period_min/period_max tracking.
module clk_duty_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned DUTY_EXP = 50,
    parameter int unsigned DUTY_TOL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic [6:0]       duty_pct,
    output logic             duty_err,
    output logic             stuck,
    output logic             stuck_lvl,
    output logic             overrun
`ifdef CLK_MON_MINMAX_EN
    ,
    output logic [CNT_W:0]   period_min,
    output logic [CNT_W:0]   period_max
`endif
);

    localparam int unsigned NUM_W = CNT_W + 7;

    logic             sync1_q, s_q, s_d_q;
    logic             rise, fall;
    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             close, timeout, accept, drop;
    logic [CNT_W-1:0] hand_h_q, hand_l_q;
    logic             start_q;
    logic [NUM_W-1:0] div_num;
    logic [CNT_W:0]   div_den;
    logic             div_busy, div_done;
    logic [6:0]       div_quot;

    logic             meas_valid_q, duty_err_q, stuck_q, stuck_lvl_q, overrun_q;
    logic [CNT_W-1:0] high_q, low_q;
    logic [CNT_W:0]   period_q;
    logic [6:0]       duty_q;

    assign rise = s_q & ~s_d_q;
    assign fall = ~s_q & s_d_q;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            s_d_q   <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            s_q     <= sync1_q;
            s_d_q   <= s_q;
        end
    end

    // Measurement FSM state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Next state: edges win over timeout; en low forces IDLE.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        close   = 1'b0;
        timeout = 1'b0;
        if (!en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StMeasHigh;
                        hcnt_d  = CNT_W'(1);
                    end
                end
                StMeasHigh: begin
                    if (fall) begin
                        state_d = StMeasLow;
                        lcnt_d  = CNT_W'(1);
                    end else if (hcnt_q == CNT_W'(TIMEOUT)) begin
                        timeout = 1'b1;
                        state_d = StIdle;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                    end
                end
                StMeasLow: begin
                    if (rise) begin
                        close   = 1'b1;
                        state_d = StMeasHigh;
                        hcnt_d  = CNT_W'(1);
                    end else if (lcnt_q == CNT_W'(TIMEOUT)) begin
                        timeout = 1'b1;
                        state_d = StIdle;
                    end else begin
                        lcnt_d = lcnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A period closing while a division is pending or running is dropped.
    assign accept = close & ~(start_q | div_busy);
    assign drop   = close & (start_q | div_busy);

    // Capture the closed period and kick the divider one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 1'b0;
            hand_h_q <= '0;
            hand_l_q <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                hand_h_q <= hcnt_q;
                hand_l_q <= lcnt_q;
            end
        end
    end

    assign div_num = NUM_W'(hand_h_q) * NUM_W'(PCT_SCALE);
    assign div_den = {1'b0, hand_h_q} + {1'b0, hand_l_q};

    clk_mon_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // Result, stuck and overrun registers; results all change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid_q <= 1'b0;
            high_q       <= '0;
            low_q        <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            duty_err_q   <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_lvl_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            meas_valid_q <= div_done;
            stuck_q      <= timeout;
            if (div_done) begin
                high_q     <= hand_h_q;
                low_q      <= hand_l_q;
                period_q   <= div_den;
                duty_q     <= div_quot;
                duty_err_q <= duty_out_of_tol(div_quot, DUTY_EXP, DUTY_TOL);
            end
            if (timeout) begin
                stuck_lvl_q <= s_q;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign meas_valid = meas_valid_q;
    assign high_cnt   = high_q;
    assign low_cnt    = low_q;
    assign period_cnt = period_q;
    assign duty_pct   = duty_q;
    assign duty_err   = duty_err_q;
    assign stuck      = stuck_q;
    assign stuck_lvl  = stuck_lvl_q;
    assign overrun    = overrun_q;

`ifdef CLK_MON_MINMAX_EN
    logic           en_q;
    logic [CNT_W:0] pmin_q, pmax_q;

    // Min/max of reported periods; cleared on reset and on en rising.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            pmin_q <= '1;
            pmax_q <= '0;
        end else begin
            en_q <= en;
            if (en && !en_q) begin
                pmin_q <= '1;
                pmax_q <= '0;
            end else if (div_done) begin
                if (div_den < pmin_q) begin
                    pmin_q <= div_den;
                end
                if (div_den > pmax_q) begin
                    pmax_q <= div_den;
                end
            end
        end
    end

    assign period_min = pmin_q;
    assign period_max = pmax_q;
`endif

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Self-checking bench for clk_duty_monitor with a period-level reference model.
module tb_clk_duty_monitor;

    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 1000;
    localparam int DUTY_EXP = 60;
    localparam int DUTY_TOL = 2;
    localparam int LAT      = 11;  // sig_in rise drive to meas_valid, incl. sync
    localparam int MIN_GAP  = 9;   // closings closer than this to an accepted one drop

    typedef struct packed {
        int               cyc;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] l;
        logic [CNT_W:0]   p;
        logic [6:0]       d;
        logic             e;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst, en, sig_in;
    logic             meas_valid, duty_err, stuck, stuck_lvl, overrun;
    logic [CNT_W-1:0] high_cnt, low_cnt;
    logic [CNT_W:0]   period_cnt;
    logic [6:0]       duty_pct;
`ifdef CLK_MON_MINMAX_EN
    logic [CNT_W:0]   period_min, period_max;
`endif

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    meas_t obs_q[$];
    meas_t exp_q[$];
    int    stk_cyc[$];
    logic  stk_lvl[$];
    int    wh[$];
    int    wl[$];
    int    last_acc;
    logic  ov_exp;

    clk_duty_monitor #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .DUTY_EXP (DUTY_EXP),
        .DUTY_TOL (DUTY_TOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period_cnt (period_cnt),
        .duty_pct   (duty_pct),
        .duty_err   (duty_err),
        .stuck      (stuck),
        .stuck_lvl  (stuck_lvl),
        .overrun    (overrun)
`ifdef CLK_MON_MINMAX_EN
        ,
        .period_min (period_min),
        .period_max (period_max)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            obs_q.push_back(meas_t'{cyc, high_cnt, low_cnt, period_cnt, duty_pct, duty_err});
        end
        if (stuck === 1'b1) begin
            stk_cyc.push_back(cyc);
            stk_lvl.push_back(stuck_lvl);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v);
        @(posedge clk);
        #1;
        sig_in = v;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        en     = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        stk_cyc.delete();
        stk_lvl.delete();
        last_acc = -1000;
        ov_exp   = 1'b0;
    endtask

    // Reference: a period closes at a rise; reported unless the previous
    // accepted closing is still being divided.
    task automatic model_close(input int c, input int h, input int l);
        meas_t m;
        int    d;
        int    diff;
        if (c - last_acc >= MIN_GAP) begin
            d     = (h * 100) / (h + l);
            diff  = (d > DUTY_EXP) ? d - DUTY_EXP : DUTY_EXP - d;
            m.cyc = c + LAT;
            m.h   = CNT_W'(h);
            m.l   = CNT_W'(l);
            m.p   = (CNT_W + 1)'(h + l);
            m.d   = 7'(d);
            m.e   = (diff > DUTY_TOL);
            exp_q.push_back(m);
            last_acc = c;
        end else begin
            ov_exp = 1'b1;
        end
    endtask

    // Drives wh/wl periods from a low start, ending with a closing rise.
    task automatic run_wave();
        int c;
        repeat (3) step(1'b0);
        for (int i = 0; i <= wh.size(); i++) begin
            step(1'b1);
            c = cyc;
            if (i > 0) model_close(c, wh[i-1], wl[i-1]);
            if (i == wh.size()) break;
            repeat (wh[i] - 1) step(1'b1);
            repeat (wl[i]) step(1'b0);
        end
        repeat (15) step(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 9;
        if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset meas_valid: got %b want 0", meas_valid); end
        if (high_cnt !== '0) begin errors++; $display("FAIL reset high_cnt: got %0d want 0", high_cnt); end
        if (low_cnt !== '0) begin errors++; $display("FAIL reset low_cnt: got %0d want 0", low_cnt); end
        if (period_cnt !== '0) begin errors++; $display("FAIL reset period_cnt: got %0d want 0", period_cnt); end
        if (duty_pct !== '0) begin errors++; $display("FAIL reset duty_pct: got %0d want 0", duty_pct); end
        if (duty_err !== 1'b0) begin errors++; $display("FAIL reset duty_err: got %b want 0", duty_err); end
        if (stuck !== 1'b0) begin errors++; $display("FAIL reset stuck: got %b want 0", stuck); end
        if (stuck_lvl !== 1'b0) begin errors++; $display("FAIL reset stuck_lvl: got %b want 0", stuck_lvl); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
`ifdef CLK_MON_MINMAX_EN
        checks += 2;
        if (period_min !== '1) begin errors++; $display("FAIL reset period_min: got %0d want all-ones", period_min); end
        if (period_max !== '0) begin errors++; $display("FAIL reset period_max: got %0d want 0", period_max); end
`endif
    endtask

    // Scenario 0: fixed duties around the tolerance band; 1: 1/2 overrun; 2: random.
    task automatic test_measure();
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            wh.delete();
            wl.delete();
            if (sc == 0) begin
                wh = '{6, 6, 83, 62, 63, 58, 57, 61};
                wl = '{4, 4, 17, 38, 37, 42, 43, 39};
            end else if (sc == 1) begin
                for (int i = 0; i < 12; i++) begin wh.push_back(1); wl.push_back(2); end
            end else begin
                for (int i = 0; i < 25; i++) begin
                    wh.push_back(int'($urandom_range(1, 30)));
                    wl.push_back(int'($urandom_range(1, 30)));
                end
            end
            run_wave();
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL meas_count sc=%0d: got %0d want %0d", sc, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL meas sc=%0d #%0d: got cyc=%0d h=%0d l=%0d p=%0d d=%0d e=%0d want cyc=%0d h=%0d l=%0d p=%0d d=%0d e=%0d",
                             sc, i, obs_q[i].cyc, obs_q[i].h, obs_q[i].l, obs_q[i].p, obs_q[i].d, obs_q[i].e,
                             exp_q[i].cyc, exp_q[i].h, exp_q[i].l, exp_q[i].p, exp_q[i].d, exp_q[i].e);
                end
            end
            checks++;
            if (overrun !== ov_exp) begin
                errors++;
                $display("FAIL overrun sc=%0d: got %b want %b", sc, overrun, ov_exp);
            end
        end
    endtask

    task automatic test_stuck();
        int k;
        do_reset();
        repeat (3) step(1'b0);
        step(1'b1);
        k = cyc;
        repeat (1010) step(1'b1);
        checks += 3;
        if (stk_cyc.size() != 1 || stk_cyc[0] != k + TIMEOUT + 3) begin
            errors++;
            $display("FAIL stuck_high timing: got n=%0d cyc=%0d want n=1 cyc=%0d",
                     stk_cyc.size(), (stk_cyc.size() > 0) ? stk_cyc[0] : -1, k + TIMEOUT + 3);
        end
        if (stk_lvl.size() < 1 || stk_lvl[0] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_high level: got %b want 1", (stk_lvl.size() > 0) ? stk_lvl[0] : 1'bx);
        end
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL stuck_high meas_valid: got %0d reports want 0", obs_q.size());
        end
        // After the timeout the monitor must have discarded its partial period.
        repeat (5) step(1'b0);
        repeat (5) step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        k = cyc;
        repeat (15) step(1'b1);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].h !== CNT_W'(5) || obs_q[0].l !== CNT_W'(5)
            || obs_q[0].cyc != k + LAT) begin
            errors++;
            $display("FAIL stuck_idle: got n=%0d h=%0d l=%0d cyc=%0d want n=1 h=5 l=5 cyc=%0d",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].h : '0,
                     (obs_q.size() > 0) ? obs_q[0].l : '0,
                     (obs_q.size() > 0) ? obs_q[0].cyc : -1, k + LAT);
        end
        step(1'b0);
        k = cyc;
        repeat (1010) step(1'b0);
        checks++;
        if (stk_cyc.size() != 2 || stk_cyc[1] != k + TIMEOUT + 3 || stk_lvl[1] !== 1'b0) begin
            errors++;
            $display("FAIL stuck_low: got n=%0d cyc=%0d lvl=%b want n=2 cyc=%0d lvl=0",
                     stk_cyc.size(), (stk_cyc.size() > 1) ? stk_cyc[1] : -1,
                     (stk_lvl.size() > 1) ? stk_lvl[1] : 1'bx, k + TIMEOUT + 3);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (3) step(1'b0);
        repeat (5) step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        sig_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (14) step(1'b0);
        checks += 3;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid meas_valid: got %0d reports want 0", obs_q.size());
        end
        if (high_cnt !== '0 || low_cnt !== '0 || duty_pct !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got h=%0d l=%0d d=%0d want 0 0 0", high_cnt, low_cnt, duty_pct);
        end
        wh = '{5, 5};
        wl = '{5, 5};
        run_wave();
        if (obs_q.size() != exp_q.size() || obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rst_mid recovery: got n=%0d cyc=%0d want n=%0d cyc=%0d", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].cyc : -1, exp_q.size(), exp_q[0].cyc);
        end
    endtask

    task automatic test_enable();
        do_reset();
        wh = '{7};
        wl = '{6};
        // Custom tail: drop en right after the closing rise has been taken.
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (6) step(1'b1);
        repeat (6) step(1'b0);
        step(1'b1);
        model_close(cyc, 7, 6);
        repeat (3) step(1'b1);
        en = 1'b0;
        repeat (15) step(1'b1);
        for (int i = 0; i < 3; i++) begin
            repeat (4) step(1'b0);
            repeat (4) step(1'b1);
        end
        repeat (5) step(1'b0);
        checks += 2;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL en_inflight: got n=%0d cyc=%0d h=%0d want n=1 cyc=%0d h=7",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].cyc : -1,
                     (obs_q.size() > 0) ? obs_q[0].h : '0, exp_q[0].cyc);
        end
        if (high_cnt !== CNT_W'(7) || low_cnt !== CNT_W'(6)) begin
            errors++;
            $display("FAIL en_hold: got h=%0d l=%0d want h=7 l=6", high_cnt, low_cnt);
        end
        en = 1'b1;
        wh = '{6, 9};
        wl = '{3, 11};
        run_wave();
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q[1] !== exp_q[1] || obs_q[2] !== exp_q[2]) begin
            errors++;
            $display("FAIL en_resume: got n=%0d want n=%0d", obs_q.size(), exp_q.size());
        end
    endtask

`ifdef CLK_MON_MINMAX_EN
    task automatic test_minmax();
        int pmin, pmax;
        do_reset();
        wh = '{5, 7, 2, 4};
        wl = '{5, 7, 2, 4};
        run_wave();
        pmin = 1 << 30;
        pmax = 0;
        foreach (exp_q[i]) begin
            if (int'(exp_q[i].p) < pmin) pmin = int'(exp_q[i].p);
            if (int'(exp_q[i].p) > pmax) pmax = int'(exp_q[i].p);
        end
        checks += 2;
        if (period_min !== (CNT_W + 1)'(pmin)) begin
            errors++;
            $display("FAIL period_min: got %0d want %0d", period_min, pmin);
        end
        if (period_max !== (CNT_W + 1)'(pmax)) begin
            errors++;
            $display("FAIL period_max: got %0d want %0d", period_max, pmax);
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (period_min !== '1 || period_max !== '0) begin
            errors++;
            $display("FAIL minmax_clear: got min=%0d max=%0d want all-ones 0", period_min, period_max);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        test_reset();
        test_measure();
        test_stuck();
        test_rst_mid();
        test_enable();
`ifdef CLK_MON_MINMAX_EN
        test_minmax();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
